// File: rtl/uart_periph.sv
// rtl/uart_periph.sv - memory-mapped 8N1 UART with TX holding register and RX FIFO
module uart_periph #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_enable,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] uart_data,
  input  logic        rx,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // bus decode
  logic sel_data, sel_stat, rd_pop, wr_data, wr_stat;

  // transmit side
  logic [7:0]    thr;
  logic          thr_full;
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_load;

  // receive side
  logic          rx_meta, rx_sync;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          stop_done, stop_bit;
  logic          rx_push, rx_ferr;

  // receive FIFO and sticky flags
  logic [7:0]    mem [RX_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          fifo_empty, fifo_full, push_ok;
  logic          overrun, frame_err;
  logic [5:0]    status;

  // only a handful of write-data bits carry meaning
  logic          unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign sel_data = uart_enable && (addr == 4'h0);
  assign sel_stat = uart_enable && (addr == 4'h4);
  assign rd_pop   = sel_data && !we && !fifo_empty;
  assign wr_data  = sel_data && we;
  assign wr_stat  = sel_stat && we;

  assign tx_load  = (tx_state == ST_IDLE) && thr_full;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // a pop in the same cycle frees the slot the push needs
  assign push_ok    = rx_push && (!fifo_full || rd_pop);

  assign rx_push = (rx_state == ST_STOP) && stop_done && stop_bit;
  assign rx_ferr = (rx_state == ST_STOP) && stop_done && !stop_bit;

  assign status = {frame_err, overrun, (tx_state != ST_IDLE), !thr_full, fifo_full, !fifo_empty};

  // holding register: accept a byte only while empty, release it to the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr      <= 8'h00;
      thr_full <= 1'b0;
    end else if (tx_load) begin
      thr_full <= 1'b0;
    end else if (wr_data && !thr_full) begin
      thr      <= wdata[7:0];
      thr_full <= 1'b1;
    end
  end

  // transmit FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (thr_full) begin
            tx_shift <= thr;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx       <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // two-flop synchronizer for the asynchronous serial input, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // receive FSM: confirm start at mid-bit, then sample every bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= ST_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      stop_done <= 1'b0;
      stop_bit  <= 1'b0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          stop_done <= 1'b0;
          if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          // stop bit is captured at mid-bit; the byte is resolved one cycle later
          if (stop_done) begin
            stop_done <= 1'b0;
            rx_cnt    <= '0;
            rx_state  <= ST_IDLE;
          end else if (rx_cnt == BIT_LAST) begin
            stop_bit  <= rx_sync;
            stop_done <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= rx_shift;
  end

  // FIFO pointers, one extra bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (rd_pop)  rptr <= rptr + 1'b1;
    end
  end

  // sticky error flags; a set event outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_push && fifo_full && !rd_pop) overrun <= 1'b1;
      else if (wr_stat && wdata[4])        overrun <= 1'b0;
      if (rx_ferr)                         frame_err <= 1'b1;
      else if (wr_stat && wdata[5])        frame_err <= 1'b0;
    end
  end

  // combinational read data for the CPU read-data select stage
  always_comb begin
    uart_data = 32'h0;
    if (uart_enable) begin
      case (addr)
        4'h0:    if (!fifo_empty) uart_data = {24'h0, mem[rptr[AW-1:0]]};
        4'h4:    uart_data = {26'h0, status};
        default: uart_data = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb/tb_uart_periph.sv - self-checking bench for uart_periph with a queue-based model
module tb_uart_periph;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 10 * CPB;
  localparam int PUSH_CYC = FRAME + 1;
  localparam int WAVE_N   = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_enable;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] uart_data;
  logic        rx;
  logic        tx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // model: received bytes in arrival order plus the two sticky flags
  logic [7:0] rxq[$];
  logic       m_overrun;
  logic       m_ferr;

  logic exp_w [WAVE_N];
  logic got_w [WAVE_N];

  always #5 clk = ~clk;

  uart_periph #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_enable(uart_enable), .we(we), .addr(addr),
    .wdata(wdata), .uart_data(uart_data), .rx(rx), .tx(tx)
  );

  function automatic logic [31:0] exp_status();
    return {26'h0, m_ferr, m_overrun, 1'b0, 1'b1, (rxq.size() == DEPTH), (rxq.size() != 0)};
  endfunction

  function automatic logic [31:0] m_pop();
    if (rxq.size() == 0) return 32'h0;
    return {24'h0, rxq.pop_front()};
  endfunction

  task automatic clear_wave();
    for (int i = 0; i < WAVE_N; i++) begin
      exp_w[i] = 1'b1;
      got_w[i] = 1'b1;
    end
  endtask

  task automatic put_frame(input int off, input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CPB; c++) exp_w[off + k * CPB + c] = fr[k];
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    uart_enable = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    uart_enable = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    uart_enable = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = uart_data;
    @(posedge clk); #1;
    uart_enable = 1'b0;
  endtask

  // drive one serial frame on rx, optionally reading DATA on cycle pop_cyc
  task automatic send_rx(input logic [7:0] b, input logic stop_val, input int pop_cyc,
                         output logic [31:0] pd, output logic [31:0] exp_pd);
    logic [9:0] fr;
    fr = {stop_val, b, 1'b0};
    pd = 32'h0;
    exp_pd = 32'h0;
    for (int c = 0; c < FRAME + 6; c++) begin
      rx = (c < FRAME) ? fr[c / CPB] : 1'b1;
      uart_enable = (c == pop_cyc); we = 1'b0; addr = 4'h0;
      @(negedge clk);
      if (c == pop_cyc) pd = uart_data;
      @(posedge clk); #1;
    end
    uart_enable = 1'b0;
    if (!stop_val) begin
      m_ferr = 1'b1;
    end else begin
      if (pop_cyc == PUSH_CYC) exp_pd = m_pop();
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else m_overrun = 1'b1;
    end
  endtask

  task automatic compare_wave(input string name, input int n);
    int bad; int first;
    bad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (got_w[i] !== exp_w[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    total_cnt++;
    if (bad != 0)
      $display("FAIL %s: %0d wrong cycles, first at %0d got %b expected %b",
               name, bad, first, got_w[first], exp_w[first]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; rx = 1'b1; uart_enable = 1'b0; we = 1'b0; addr = 4'h0; wdata = 32'h0;
    rxq.delete(); m_overrun = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else pass_cnt++;
    total_cnt++;
    if (uart_data !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", uart_data); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL reset_status: got %h expected 00000004", d); else pass_cnt++;
    bus_read(4'h0, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_data: got %h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_tx_frame();
    logic [31:0] s_busy;
    logic [31:0] d;
    clear_wave();
    put_frame(2, 8'hA5);
    put_frame(2 + FRAME + 1, 8'h3C);
    s_busy = 32'h0;
    for (int i = 0; i < 100; i++) begin
      uart_enable = 1'b0; we = 1'b0;
      if (i == 0) begin uart_enable = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'hA5; end
      if (i == 2) begin uart_enable = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h3C; end
      if (i == 3) begin uart_enable = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h99; end
      if (i == 5) begin uart_enable = 1'b1; we = 1'b0; addr = 4'h4; end
      @(negedge clk);
      got_w[i] = tx;
      if (i == 5) s_busy = uart_data;
      @(posedge clk); #1;
    end
    uart_enable = 1'b0; we = 1'b0;
    compare_wave("tx_a5_3c_drop99", 100);
    total_cnt++;
    if (s_busy !== 32'h8) $display("FAIL tx_busy_status: got %h expected 00000008", s_busy); else pass_cnt++;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== exp_status()) $display("FAIL tx_idle_status: got %h expected %h", d, exp_status()); else pass_cnt++;
  endtask

  task automatic test_rx_byte();
    logic [31:0] d, pd, epd;
    send_rx(8'h5A, 1'b1, -1, pd, epd);
    bus_read(4'h4, d);
    total_cnt++;
    if (d[0] !== 1'b1) $display("FAIL rx_valid_set: got %b expected 1", d[0]); else pass_cnt++;
    bus_read(4'h0, d);
    total_cnt++;
    if (d !== 32'h5A) $display("FAIL rx_data: got %h expected 0000005a", d); else pass_cnt++;
    void'(m_pop());
    bus_read(4'h4, d);
    total_cnt++;
    if (d[0] !== 1'b0) $display("FAIL rx_valid_clr: got %b expected 0", d[0]); else pass_cnt++;
  endtask

  task automatic test_fifo_overrun();
    logic [31:0] d, pd, epd, e;
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, -1, pd, epd);
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== 32'h17 || d !== exp_status())
      $display("FAIL overrun_status: got %h expected 00000017", d);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus_read(4'h0, d);
      e = m_pop();
      total_cnt++;
      if (d !== e) $display("FAIL overrun_read%0d: got %h expected %h", i, d, e); else pass_cnt++;
    end
    bus_write(4'h4, 32'h10);
    m_overrun = 1'b0;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== exp_status()) $display("FAIL overrun_clear: got %h expected %h", d, exp_status()); else pass_cnt++;
  endtask

  task automatic test_framing_glitch();
    logic [31:0] d, pd, epd;
    send_rx(8'hC3, 1'b0, -1, pd, epd);
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== exp_status()) $display("FAIL frame_err_status: got %h expected %h", d, exp_status()); else pass_cnt++;
    bus_write(4'h4, 32'h20);
    m_ferr = 1'b0;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== exp_status()) $display("FAIL glitch_status: got %h expected %h", d, exp_status()); else pass_cnt++;
    bus_read(4'h0, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL glitch_data: got %h expected 0", d); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    logic [31:0] d, pd, epd, e;
    for (int i = 0; i < DEPTH; i++) send_rx(8'($urandom), 1'b1, -1, pd, epd);
    send_rx(8'h77, 1'b1, PUSH_CYC, pd, epd);
    total_cnt++;
    if (pd !== epd) $display("FAIL pushpop_read: got %h expected %h", pd, epd); else pass_cnt++;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== exp_status()) $display("FAIL pushpop_status: got %h expected %h", d, exp_status()); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(4'h0, d);
      e = m_pop();
      total_cnt++;
      if (d !== e) $display("FAIL pushpop_drain%0d: got %h expected %h", i, d, e); else pass_cnt++;
    end
  endtask

  task automatic test_random_rx();
    logic [31:0] d, pd, epd, e;
    int k;
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) send_rx(8'($urandom), 1'b1, -1, pd, epd);
      for (int j = 0; j <= k; j++) begin
        bus_read(4'h0, d);
        e = m_pop();
        total_cnt++;
        if (d !== e) $display("FAIL rand_rx_r%0d_%0d: got %h expected %h", r, j, d, e); else pass_cnt++;
      end
    end
  endtask

  task automatic test_random_tx();
    logic [7:0] b;
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom);
      clear_wave();
      put_frame(2, b);
      for (int i = 0; i < FRAME + 6; i++) begin
        uart_enable = (i == 0); we = (i == 0); addr = 4'h0; wdata = {24'h0, b};
        @(negedge clk);
        got_w[i] = tx;
        @(posedge clk); #1;
      end
      uart_enable = 1'b0; we = 1'b0;
      compare_wave($sformatf("rand_tx_%02h", b), FRAME + 6);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, pd, epd;
    int highs;
    send_rx(8'($urandom), 1'b1, -1, pd, epd);
    bus_write(4'h0, 32'hA5);
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (tx !== 1'b0) $display("FAIL midframe_start: got %b expected 0", tx); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tx !== 1'b1) $display("FAIL midframe_reset_tx: got %b expected 1", tx); else pass_cnt++;
    rxq.delete(); m_overrun = 1'b0; m_ferr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(4'h4, d);
    total_cnt++;
    if (d !== 32'h4) $display("FAIL midframe_status: got %h expected 00000004", d); else pass_cnt++;
    highs = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (tx === 1'b1) highs++;
    end
    total_cnt++;
    if (highs != FRAME) $display("FAIL midframe_tx_idle: got %0d high cycles expected %0d", highs, FRAME); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_byte();
    test_fifo_overrun();
    test_framing_glitch();
    test_push_pop();
    test_random_rx();
    test_random_tx();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped UART peripheral on the CPU data bus. It has a transmit holding register, a serial transmitter, a serial receiver and a receive FIFO. The address decoder drives `uart_enable`. Read data goes out on `uart_data` to the CPU read-data select stage, which forwards it to the core in the same cycle. Frame format is fixed at 8N1, LSB first.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 4.
- `RX_DEPTH`, 4: receive FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `uart_enable`  in  1  peripheral selected for the current bus access.
- `we`  in  1  write strobe, qualified by `uart_enable`.
- `addr`  in  4  byte offset within the peripheral: 0x0 DATA, 0x4 STATUS; other offsets read 0 and ignore writes.
- `wdata`  in  32  write data.
- `uart_data`  out  32  combinational read data; 0 when `uart_enable` is low.
- `rx`  in  1  serial input; asynchronous, idles high.
- `tx`  out  1  serial output; registered, idles high.

## Operation
- DATA read:
  - Returns {24'b0, FIFO head}, or 0 when the FIFO is empty.
  - Pops the head at the clock edge when `uart_enable` & !`we` & `addr`==0x0 & FIFO non-empty.
- DATA write: if the holding register is empty, load `wdata[7:0]` and mark it full. If it is full, the write is silently dropped.
- STATUS read, {26'b0, frame_err, overrun, tx_busy, tx_ready, rx_full, rx_valid} in bits [5:0]:
  - rx_valid = FIFO non-empty; rx_full = FIFO full.
  - tx_ready = holding register empty; tx_busy = TX FSM not IDLE.
  - overrun and frame_err are sticky.
- STATUS write: `wdata[4]`=1 clears overrun; `wdata[5]`=1 clears frame_err; other bits are ignored. A set event and a clear in the same cycle: set wins.
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: `tx`=1. If the holding register is full: copy it to the shift register, mark it empty, go to START, drive `tx`=0.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
  - The holding register may be refilled as soon as tx_ready=1, including during an active frame.
- RX path: `rx` passes through a 2-flop synchronizer (output initialised high). The FSM is IDLE → START → DATA → STOP.
  - IDLE: a synchronized low moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. Low → DATA; high → IDLE (glitch rejected, nothing recorded).
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit, 8 bits, LSB first.
  - STOP: sample once at mid-bit, then go to IDLE on the next cycle.
    - Sample high: push the byte. If the FIFO is full with no pop this cycle, discard the byte and set overrun.
    - Sample low: discard the byte and set frame_err.
- FIFO:
  - Read/write pointers one bit wider than log2(RX_DEPTH); wrap is modulo 2×RX_DEPTH.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: the push occurs, the read returns 0.

## Timing
- Reset values: `tx`=1; `uart_data`=0 (`uart_enable` low); FIFO empty; holding register empty; both FSMs IDLE; overrun=0; frame_err=0; STATUS reads 0x04.
- Reset is honoured mid-frame: it aborts the TX frame, drives `tx` high at once and empties the FIFO.
- `uart_data` is valid in the same cycle as `uart_enable`/`addr`. A pop or a flag clear takes effect at that cycle's edge.
- TX latency:
  - DATA write accepted at edge E → `tx` falls at edge E+1.
  - A frame spans 10×CLKS_PER_BIT cycles.
  - Back-to-back bytes: exactly one idle-high cycle between the stop bit and the next start bit.
- RX latency: rx_valid rises 1 cycle after the stop-bit mid-sample edge (plus 2 synchronizer cycles measured from the `rx` pin).
- Bit timing tolerance: mid-bit sampling must accept a sender that is ±4% off CLKS_PER_BIT.

## Test plan
Run the bench with CLKS_PER_BIT=4 and RX_DEPTH=4.
- Reset: pulse `rst_n` low mid-transmission → `tx`=1 immediately; STATUS reads 0x04 after release.
- TX frame: write DATA=0xA5 → `tx` goes low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high. Write 0x3C while busy → it is sent after exactly one idle cycle. A third write while both the holding register and shifter are busy is dropped.
- RX byte: drive 0x5A frame on `rx` → STATUS bit0=1; DATA read returns 0x0000005A, then STATUS bit0=0.
- FIFO full/overrun: receive 5 bytes 0x01..0x05 without reading → STATUS = 0x17 (rx_full, rx_valid, tx_ready, overrun). Reads return 0x01..0x04 then 0. Write STATUS 0x10 → overrun=0.
- Framing and glitch:
  - Stop bit driven low → frame_err=1, FIFO unchanged.
  - A 1-cycle low pulse on `rx` → no byte received, no flags set.
- Simultaneous push/pop: with FIFO full, pop DATA on the stop-sample cycle of byte 0x77 → no overrun, count stays 4, 0x77 is read last.
